// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the BCD digit accumulator slice.
// Defaults size the block for up to four decimal digits (0..9999).
package bcd_pkg;

    localparam int NDIG_DEF  = 4;
    localparam int BIN_W_DEF = 14;
    localparam int BCD_MAX   = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_mac10.sv
// Combinational acc*10+d step; non-BCD digits (>9) are flagged and contribute 0.
// Zero latency, no flow control (pure function of its inputs).
module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEF
) (
    input  logic [BIN_W-1:0] i_acc,
    input  logic [3:0]       i_dig,
    output logic [BIN_W-1:0] o_sum,
    output logic             o_bad
);

    logic [3:0] w_d;

    assign o_bad = (i_dig > 4'(BCD_MAX));
    assign w_d   = o_bad ? 4'd0 : i_dig;

    // x*10 as x*8 + x*2; operands stay below 10^(NDIG-1) so nothing overflows BIN_W
    assign o_sum = (i_acc << 3) + (i_acc << 1) + BIN_W'(w_d);

endmodule

// File: rtl/bcd_digit_accumulator.sv
// Folds an MSD-first BCD digit stream into a binary number; result one cycle after the last digit.
// dig_ready drops while a result waits for num_ready; it rises again the cycle after the result is taken.
module bcd_digit_accumulator
    import bcd_pkg::*;
#(
    parameter int NDIG  = NDIG_DEF,
    parameter int BIN_W = BIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       dig_in,
    input  logic             dig_valid,
    input  logic             dig_last,
    output logic             dig_ready,
    output logic [BIN_W-1:0] num_out,
    output logic [2:0]       num_ndig,
    output logic             num_err,
    output logic             num_valid,
    input  logic             num_ready
);

    state_t           r_state;
    logic [BIN_W-1:0] r_acc;
    logic [2:0]       r_cnt;
    logic             r_err;

    logic             w_dig_acc;
    logic             w_num_acc;
    logic             w_first;
    logic [BIN_W-1:0] w_acc_base;
    logic [BIN_W-1:0] w_sum;
    logic             w_bad;
    logic [2:0]       w_cnt_nxt;
    logic             w_done;

    assign dig_ready = (r_state != ST_OUT);
    assign num_valid = (r_state == ST_OUT);
    assign w_dig_acc = dig_valid & dig_ready;
    assign w_num_acc = num_valid & num_ready;

    // The first digit of a number starts from a zero base, so one MAC covers both load and update
    assign w_first    = (r_state == ST_IDLE);
    assign w_acc_base = w_first ? '0 : r_acc;
    assign w_cnt_nxt  = (w_first ? 3'd0 : r_cnt) + 3'd1;
    assign w_done     = dig_last | (w_cnt_nxt == 3'(NDIG));

    bcd_mac10 #(
        .BIN_W (BIN_W)
    ) u_mac10 (
        .i_acc (w_acc_base),
        .i_dig (dig_in),
        .o_sum (w_sum),
        .o_bad (w_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= 3'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACC: begin
                    if (w_dig_acc) begin
                        r_acc   <= w_sum;
                        r_cnt   <= w_cnt_nxt;
                        r_err   <= (r_err & ~w_first) | w_bad;
                        r_state <= w_done ? ST_OUT : ST_ACC;
                    end
                end
                ST_OUT: begin
                    if (w_num_acc) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign num_out  = r_acc;
    assign num_ndig = r_cnt;
    assign num_err  = r_err;

endmodule

// File: tb/tb_bcd_digit_accumulator.sv
// Directed bench: inputs change and outputs are sampled on the falling clock edge.
module tb_bcd_digit_accumulator;

    logic        clk;
    logic        rst_n;
    logic [3:0]  dig_in;
    logic        dig_valid;
    logic        dig_last;
    logic        dig_ready;
    logic [13:0] num_out;
    logic [2:0]  num_ndig;
    logic        num_err;
    logic        num_valid;
    logic        num_ready;

    int errors;
    int checks;

    bcd_digit_accumulator #(
        .NDIG  (4),
        .BIN_W (14)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dig_in    (dig_in),
        .dig_valid (dig_valid),
        .dig_last  (dig_last),
        .dig_ready (dig_ready),
        .num_out   (num_out),
        .num_ndig  (num_ndig),
        .num_err   (num_err),
        .num_valid (num_valid),
        .num_ready (num_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] d, input logic last);
        dig_in    = d;
        dig_valid = 1'b1;
        dig_last  = last;
        @(negedge clk);
        dig_valid = 1'b0;
        dig_last  = 1'b0;
    endtask

    task automatic chk_result(input string tag, input int val, input int nd, input int er);
        chk({tag, "_valid"}, int'(num_valid), 1);
        chk({tag, "_rdy"},   int'(dig_ready), 0);
        chk({tag, "_out"},   int'(num_out),   val);
        chk({tag, "_ndig"},  int'(num_ndig),  nd);
        chk({tag, "_err"},   int'(num_err),   er);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        dig_in    = 4'd0;
        dig_valid = 1'b0;
        dig_last  = 1'b0;
        num_ready = 1'b1;

        // Reset state
        #3;
        chk("rst_valid", int'(num_valid), 0);
        chk("rst_rdy",   int'(dig_ready), 1);
        chk("rst_out",   int'(num_out),   0);
        chk("rst_ndig",  int'(num_ndig),  0);
        chk("rst_err",   int'(num_err),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1,2,3,4 without dig_last: terminates on digit count
        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        send(4'd3, 1'b0);
        chk("t1_pre_valid", int'(num_valid), 0);
        send(4'd4, 1'b0);
        chk_result("t1", 1234, 4, 0);
        @(negedge clk);
        chk("t1_idle_valid", int'(num_valid), 0);
        chk("t1_idle_rdy",   int'(dig_ready), 1);

        // 0,7 with dig_last on 7
        send(4'd0, 1'b0);
        send(4'd7, 1'b1);
        chk_result("t2", 7, 2, 0);
        @(negedge clk);

        // 9, 0xC, 5 last: bad digit counts as 0 and flags err
        send(4'd9, 1'b0);
        send(4'hC, 1'b0);
        send(4'd5, 1'b1);
        chk_result("t3", 905, 3, 1);
        @(negedge clk);
        send(4'd4, 1'b1);
        chk_result("t3b", 4, 1, 0);
        @(negedge clk);

        // 9999 held while num_ready is low; stray digits ignored
        num_ready = 1'b0;
        send(4'd9, 1'b0);
        send(4'd9, 1'b0);
        send(4'd9, 1'b0);
        send(4'd9, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk_result("t4_hold", 9999, 4, 0);
            dig_in    = 4'd3;
            dig_valid = 1'b1;
            dig_last  = 1'b1;
            @(negedge clk);
        end
        dig_valid = 1'b0;
        dig_last  = 1'b0;
        chk_result("t4_end", 9999, 4, 0);
        num_ready = 1'b1;
        @(negedge clk);
        chk("t4_idle_valid", int'(num_valid), 0);
        chk("t4_idle_rdy",   int'(dig_ready), 1);
        chk("t4_idle_out",   int'(num_out),   9999);

        // Reset in the middle of a number
        send(4'd3, 1'b0);
        send(4'd8, 1'b0);
        chk("t5_partial", int'(num_out), 38);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out",   int'(num_out),   0);
        chk("t5_rst_ndig",  int'(num_ndig),  0);
        chk("t5_rst_valid", int'(num_valid), 0);
        chk("t5_rst_rdy",   int'(dig_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        send(4'd6, 1'b1);
        chk_result("t5", 6, 1, 0);
        @(negedge clk);

        // dig_valid pattern 1,0,0,1,1
        send(4'd2, 1'b0);
        dig_in = 4'd9;
        @(negedge clk);
        chk("t6_gap1", int'(num_out), 2);
        @(negedge clk);
        chk("t6_gap2",       int'(num_out),   2);
        chk("t6_gap2_valid", int'(num_valid), 0);
        send(4'd4, 1'b0);
        send(4'd1, 1'b1);
        chk_result("t6", 241, 3, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_digit_accumulator.md
BCD_DIGIT_ACCUMULATOR -- requirements
Module: bcd_digit_accumulator

Interface
REQ-001 SHALL have parameter NDIG, default 4: maximum BCD digits per number (range 1..4).
REQ-002 SHALL have parameter BIN_W, default 14: binary result width, sized for 10^NDIG-1 (9999 at NDIG=4).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port dig_in, input, 4: BCD digit, most significant first, sourced from the Excess-3-to-BCD stage.
REQ-006 SHALL have port dig_valid, input, 1: dig_in is valid.
REQ-007 SHALL have port dig_last, input, 1: qualified by dig_valid; marks the final digit of the current number.
REQ-008 SHALL have port dig_ready, output, 1: block accepts a digit this cycle.
REQ-009 SHALL have port num_out, output, BIN_W: accumulated binary value.
REQ-010 SHALL have port num_ndig, output, 3: count of digits in num_out (1..NDIG).
REQ-011 SHALL have port num_err, output, 1: at least one non-BCD digit (>9) was seen in this number.
REQ-012 SHALL have port num_valid, output, 1: num_out, num_ndig and num_err are valid.
REQ-013 SHALL have port num_ready, input, 1: consumer accepts the result.

Function
REQ-014 SHALL implement FSM states IDLE, ACC and OUT.
REQ-015 SHALL define digit accept as dig_valid & dig_ready.
REQ-016 SHALL define result accept as num_valid & num_ready.
REQ-017 SHALL drive dig_ready=1 in IDLE and ACC, and 0 in OUT.
REQ-018 SHALL drive num_valid=1 only in OUT.
REQ-019 On a digit accept in IDLE, SHALL load acc=d, cnt=1, err=(dig_in>9).
REQ-020 On a digit accept in ACC, SHALL update acc=acc*10+d (computed as (acc<<3)+(acc<<1)+d), set cnt=cnt+1, and set err|=(dig_in>9).
REQ-021 SHALL use d=dig_in when dig_in<=9 and d=0 otherwise, so the result stays within 0..10^NDIG-1.
REQ-022 SHALL go to OUT on a digit accept with dig_last=1 or with the new cnt==NDIG.
REQ-023 On any other digit accept from IDLE, SHALL go to ACC.
REQ-024 SHALL stay in IDLE or ACC with all state held while no digit is accepted.
REQ-025 SHALL assert the result (num_valid) the cycle after the final digit is accepted (latency 1).
REQ-026 In OUT, SHALL hold num_out, num_ndig and num_err stable until result accept.
REQ-027 On result accept, SHALL go to IDLE next cycle; no same-cycle digit bypass, so dig_ready first rises that next cycle.
REQ-028 SHALL ignore dig_valid and dig_last while in OUT.
REQ-029 SHALL assert dig_last on the NDIG-th digit as redundant and harmless, producing a single termination.
REQ-030 SHALL drive num_out, num_ndig and num_err straight from the acc, cnt and err registers, with no combinational path from inputs to outputs.

Reset
REQ-031 On rst_n=0, SHALL immediately force state=IDLE and acc, cnt, err all to 0.
REQ-032 SHALL therefore drive num_valid=0, dig_ready=1, num_out=0, num_ndig=0 and num_err=0 from reset.
REQ-033 On reset mid-number or mid-OUT, SHALL discard the partial or pending result with no output.
REQ-034 SHALL accept a digit on the first rising clk edge after rst_n deasserts.

Structure
REQ-035 SHALL place NDIG_DEF, BIN_W_DEF, BCD_MAX=9 and the state enum type in a shared package bcd_pkg.
REQ-036 SHALL use one combinational sub-module, bcd_mac10, computing acc*10+d with the >9 masking.
REQ-037 SHALL contain the FSM, counter and registers in the top-level module.

Verification
REQ-038 SHALL cover: digits 1,2,3,4 on consecutive cycles, no dig_last -> num_out=1234, num_ndig=4, num_err=0, num_valid rising the cycle after digit 4.
REQ-039 SHALL cover: digits 0,7 with dig_last on 7 -> num_out=7, num_ndig=2, num_err=0.
REQ-040 SHALL cover: digits 9,12(0xC),5,dig_last -> num_out=905, num_ndig=3, num_err=1; the next number 4,dig_last -> num_err=0.
REQ-041 SHALL cover: 9,9,9,9 with num_ready low for 5 cycles -> num_out=9999 held stable, dig_ready=0 and extra dig_valid ignored throughout; num_ready high -> IDLE next cycle.
REQ-042 SHALL cover: digits 3,8, then rst_n low mid-cycle -> outputs clear immediately; after release, 6,dig_last -> num_out=6, num_ndig=1.
REQ-043 SHALL cover: dig_valid toggling 1,0,0,1,1 with digits 2,_,_,4,1 -> num_out=241; no accumulation while dig_valid=0.
